// File: rtl/seq_bcd_converter_cgrundey_pkg.sv
// rtl/seq_bcd_converter_cgrundey_pkg.sv - shared encodings and helpers for the BCD/binary converter
// Enumerations and constant helpers shared by the converter top and its digit adjuster.
package conv_pkg_cgrundey;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_e;

  localparam logic MODE_BIN2BCD = 1'b0;
  localparam logic MODE_BCD2BIN = 1'b1;

  // Largest value representable in the given number of BCD digits (10^digits - 1).
  function automatic longint unsigned bcd_max_val(input int digits);
    longint unsigned v;
    v = 1;
    for (int i = 0; i < digits; i++) begin
      v = v * 10;
    end
    return v - 1;
  endfunction

endpackage

// File: rtl/seq_bcd_converter_cgrundey_if.sv
// rtl/seq_bcd_converter_cgrundey_if.sv - request/result bundle for the BCD/binary converter
// The requester drives start/mode/operands; the converter returns results and status.
interface seq_bcd_converter_cgrundey_if #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
);
  logic                start;
  logic                mode;
  logic [BIN_W-1:0]    bin_in;
  logic [4*DIGITS-1:0] bcd_in;
  logic [4*DIGITS-1:0] bcd_out;
  logic [BIN_W-1:0]    bin_out;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, mode, bin_in, bcd_in,
    input  bcd_out, bin_out, busy, done, err
  );

  modport slave (
    input  start, mode, bin_in, bcd_in,
    output bcd_out, bin_out, busy, done, err
  );
endinterface

// File: rtl/seq_bcd_converter_cgrundey_adj.sv
// rtl/seq_bcd_converter_cgrundey_adj.sv - per-digit add-3 / subtract-3 correction
// Four-bit digit correction, no carry out; the top applies it before (bin->bcd) or after (bcd->bin) the shift.
module bcd_digit_adj_cgrundey
  import conv_pkg_cgrundey::*;
(
  input  logic [3:0] digit_i,
  input  logic       mode_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (mode_i == MODE_BIN2BCD) begin
      if (digit_i >= 4'd5) digit_o = digit_i + 4'd3;
    end else begin
      if (digit_i >= 4'd8) digit_o = digit_i - 4'd3;
    end
  end

endmodule

// File: rtl/seq_bcd_converter_cgrundey.sv
// rtl/seq_bcd_converter_cgrundey.sv - iterative BCD<->binary converter, one bit per clock
// IDLE captures and range-checks, CONV runs BIN_W shift steps, DONE loads the result pair.
module seq_bcd_converter_cgrundey
  import conv_pkg_cgrundey::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                        clk,
  input  logic                        clear,
  seq_bcd_converter_cgrundey_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(bcd_max_val(DIGITS));

  if (DIGITS < 1 || (64'd1 << BIN_W) <= bcd_max_val(DIGITS)) begin : g_bad_params
    $fatal(1, "seq_bcd_converter_cgrundey: BIN_W too narrow for DIGITS");
  end

  conv_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mode_q, bad_q;
  logic [BCD_W-1:0] sh_bcd_q, sh_bcd_d, op_bcd_q, bcd_out_q;
  logic [BIN_W-1:0] sh_bin_q, sh_bin_d, op_bin_q, bin_out_q;
  logic             busy_q, done_q, err_q;

  logic             in_bad;
  logic [BCD_W-1:0] sr_bcd, adj_in, adj_out;
  logic [BIN_W-1:0] sr_bin;

  always_comb begin
    in_bad = 1'b0;
    if (bus.mode == MODE_BIN2BCD) begin
      in_bad = (bus.bin_in > MAX_BIN);
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (bus.bcd_in[4*i +: 4] > 4'd9) in_bad = 1'b1;
      end
    end
  end

  // bin->bcd corrects the digits before shifting left; bcd->bin corrects after shifting right.
  assign {sr_bcd, sr_bin} = {sh_bcd_q, sh_bin_q} >> 1;
  assign adj_in = (mode_q == MODE_BIN2BCD) ? sh_bcd_q : sr_bcd;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj_cgrundey u_adj (
      .digit_i (adj_in[4*g +: 4]),
      .mode_i  (mode_q),
      .digit_o (adj_out[4*g +: 4])
    );
  end

  always_comb begin
    sh_bcd_d = adj_out;
    sh_bin_d = sr_bin;
    if (mode_q == MODE_BIN2BCD) {sh_bcd_d, sh_bin_d} = {adj_out, sh_bin_q} << 1;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mode_q    <= MODE_BIN2BCD;
      bad_q     <= 1'b0;
      sh_bcd_q  <= '0;
      sh_bin_q  <= '0;
      op_bcd_q  <= '0;
      op_bin_q  <= '0;
      bcd_out_q <= '0;
      bin_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mode_q   <= bus.mode;
            op_bin_q <= bus.bin_in;
            op_bcd_q <= bus.bcd_in;
            sh_bcd_q <= (bus.mode == MODE_BIN2BCD) ? '0 : bus.bcd_in;
            sh_bin_q <= (bus.mode == MODE_BIN2BCD) ? bus.bin_in : '0;
            cnt_q    <= CNT_W'(BIN_W);
            bad_q    <= in_bad;
            err_q    <= 1'b0;
            busy_q   <= !in_bad;
            state_q  <= in_bad ? DONE : CONV;
          end
        end
        CONV: begin
          sh_bcd_q <= sh_bcd_d;
          sh_bin_q <= sh_bin_d;
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          err_q   <= bad_q;
          state_q <= IDLE;
          if (bad_q) begin
            bcd_out_q <= '0;
            bin_out_q <= '0;
          end else if (mode_q == MODE_BIN2BCD) begin
            bcd_out_q <= sh_bcd_q;
            bin_out_q <= op_bin_q;
          end else begin
            bcd_out_q <= op_bcd_q;
            bin_out_q <= sh_bin_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.bcd_out = bcd_out_q;
  assign bus.bin_out = bin_out_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_seq_bcd_converter_cgrundey.sv
// tb/tb_seq_bcd_converter_cgrundey.sv - scoreboard bench for the BCD/binary converter
// Two instances: DIGITS=2/BIN_W=7 carries most scenarios, DIGITS=3/BIN_W=10 the wide cases.
module tb_seq_bcd_converter_cgrundey;

  typedef struct {
    int unsigned bcd;
    int unsigned bin;
    bit          err;
    int          t;
  } exp_t;

  logic clk;
  logic clear;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  logic prev_done0 = 1'b0;
  logic prev_done1 = 1'b0;

  seq_bcd_converter_cgrundey_if #(.DIGITS(2), .BIN_W(7))  bus0 ();
  seq_bcd_converter_cgrundey_if #(.DIGITS(3), .BIN_W(10)) bus1 ();

  seq_bcd_converter_cgrundey #(.DIGITS(2), .BIN_W(7)) u_dut0 (
    .clk   (clk),
    .clear (clear),
    .bus   (bus0)
  );

  seq_bcd_converter_cgrundey #(.DIGITS(3), .BIN_W(10)) u_dut1 (
    .clk   (clk),
    .clear (clear),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned to_bcd(input int unsigned v);
    int unsigned r, x;
    r = 0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r = r | ((x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic m, input int unsigned b, input int unsigned c, input int digits);
    exp_t e;
    int unsigned maxv, v;
    bit ok;
    maxv = 1;
    for (int i = 0; i < digits; i++) maxv = maxv * 10;
    maxv = maxv - 1;
    e.t = 0;
    e.bcd = 0;
    e.bin = 0;
    e.err = 1'b1;
    if (m == 1'b0) begin
      if (b <= maxv) begin
        e.err = 1'b0;
        e.bcd = to_bcd(b);
        e.bin = b;
      end
    end else begin
      ok = 1'b1;
      v = 0;
      for (int i = digits - 1; i >= 0; i--) begin
        if (((c >> (4 * i)) & 15) > 9) ok = 1'b0;
        v = v * 10 + ((c >> (4 * i)) & 15);
      end
      if (ok) begin
        e.err = 1'b0;
        e.bcd = c;
        e.bin = v;
      end
    end
    return e;
  endfunction

  // Called at a negedge; start is held for exactly one sampling edge.
  task automatic send(input int d, input logic m, input int unsigned b, input int unsigned c, input exp_t e_in);
    exp_t e;
    e = e_in;
    e.t = cyc + 1 + (e.err ? 1 : (d == 0 ? 8 : 11));
    if (d == 0) begin
      bus0.start = 1'b1; bus0.mode = m; bus0.bin_in = 7'(b); bus0.bcd_in = 8'(c);
      sb0.push_back(e);
    end else begin
      bus1.start = 1'b1; bus1.mode = m; bus1.bin_in = 10'(b); bus1.bcd_in = 12'(c);
      sb1.push_back(e);
    end
    @(negedge clk);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      chk("timeout_pending", sb0.size() + sb1.size(), 0);
      sb0.delete();
      sb1.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus0.done) begin
      chk("done0_width", prev_done0, 1'b0);
      chk("busy0_at_done", bus0.busy, 1'b0);
      if (sb0.size() == 0) chk("unexpected_done0", bus0.done, 1'b0);
      else begin
        e = sb0.pop_front();
        chk("bcd_out0", bus0.bcd_out, e.bcd);
        chk("bin_out0", bus0.bin_out, e.bin);
        chk("err0", bus0.err, e.err);
        chk("done0_cycle", cyc, e.t);
      end
    end
    prev_done0 <= bus0.done;
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus1.done) begin
      chk("done1_width", prev_done1, 1'b0);
      if (sb1.size() == 0) chk("unexpected_done1", bus1.done, 1'b0);
      else begin
        e = sb1.pop_front();
        chk("bcd_out1", bus1.bcd_out, e.bcd);
        chk("bin_out1", bus1.bin_out, e.bin);
        chk("err1", bus1.err, e.err);
        chk("done1_cycle", cyc, e.t);
      end
    end
    prev_done1 <= bus1.done;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fed;
    exp_t e;
    clear = 1'b1;
    bus0.start = 1'b0; bus0.mode = 1'b0; bus0.bin_in = '0; bus0.bcd_in = '0;
    bus1.start = 1'b0; bus1.mode = 1'b0; bus1.bin_in = '0; bus1.bcd_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_bcd_out", bus0.bcd_out, 0);
    chk("rst_bin_out", bus0.bin_out, 0);
    chk("rst_busy", bus0.busy, 0);
    chk("rst_done", bus0.done, 0);
    chk("rst_err", bus0.err, 0);
    clear = 1'b0;
    @(negedge clk);

    send(0, 1'b0, 99, 0, model(1'b0, 99, 0, 2));
    chk("busy_conv", bus0.busy, 1'b1);
    wait_idle();
    send(0, 1'b1, 0, 'h63, model(1'b1, 0, 'h63, 2));
    wait_idle();
    send(0, 1'b1, 0, 'h00, model(1'b1, 0, 'h00, 2));
    wait_idle();

    send(0, 1'b0, 100, 0, model(1'b0, 100, 0, 2));
    chk("busy_invalid", bus0.busy, 1'b0);
    wait_idle();
    send(0, 1'b1, 0, 'h5A, model(1'b1, 0, 'h5A, 2));
    chk("busy_invalid_bcd", bus0.busy, 1'b0);
    wait_idle();
    chk("err_held", bus0.err, 1'b1);

    send(0, 1'b0, 45, 0, model(1'b0, 45, 0, 2));
    bus0.start = 1'b1; bus0.mode = 1'b1; bus0.bin_in = 7'd12; bus0.bcd_in = 8'h12;
    repeat (2) @(negedge clk);
    bus0.start = 1'b0;
    wait_idle();

    send(0, 1'b0, 77, 0, model(1'b0, 77, 0, 2));
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    sb0.delete();
    chk("clr_bcd_out", bus0.bcd_out, 0);
    chk("clr_bin_out", bus0.bin_out, 0);
    chk("clr_busy", bus0.busy, 0);
    chk("clr_done", bus0.done, 0);

    clear = 1'b1; bus0.start = 1'b1; bus0.mode = 1'b0; bus0.bin_in = 7'd5;
    @(negedge clk);
    clear = 1'b0; bus0.start = 1'b0;
    chk("clr_start_busy", bus0.busy, 0);
    repeat (12) @(negedge clk);

    send(0, 1'b0, 10, 0, model(1'b0, 10, 0, 2));
    repeat (8) @(negedge clk);
    send(0, 1'b1, 0, 'h37, model(1'b1, 0, 'h37, 2));
    repeat (8) @(negedge clk);
    send(0, 1'b0, 88, 0, model(1'b0, 88, 0, 2));
    wait_idle();

    for (int v = 0; v < 100; v++) begin
      send(0, 1'b0, v, 0, model(1'b0, v, 0, 2));
      wait_idle();
      fed = bus0.bcd_out;
      e.bcd = to_bcd(v);
      e.bin = v;
      e.err = 1'b0;
      e.t = 0;
      send(0, 1'b1, 0, fed, e);
      wait_idle();
    end

    send(1, 1'b0, 999, 0, model(1'b0, 999, 0, 3));
    wait_idle();
    send(1, 1'b1, 0, 'h512, model(1'b1, 0, 'h512, 3));
    wait_idle();
    send(1, 1'b0, 1000, 0, model(1'b0, 1000, 0, 3));
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
